// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the default widths that match RegisterFile.
package muldiv_pkg;

  // Default operand width and register-address width (RegisterFile geometry)
  localparam int WIDTH_DEF = 32;
  localparam int AW_DEF    = 5;

  // Operation encoding presented on the op port
  typedef logic [1:0] op_t;
  localparam op_t OP_MUL  = 2'b00;  // low word of the unsigned product
  localparam op_t OP_MULH = 2'b01;  // high word of the unsigned product
  localparam op_t OP_DIVU = 2'b10;  // unsigned quotient
  localparam op_t OP_REMU = 2'b11;  // unsigned remainder

  // Control FSM state encodings
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_WB   = 2'b10;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 arithmetic core: shift-add multiplier and restoring divider.
// Both engines are loaded together and stepped together; the top picks the
// result that matches the latched operation. Outputs are the next-state
// values so the final step's result can be captured on the same edge.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_next_o,
  output logic [WIDTH-1:0]     quo_next_o,
  output logic [WIDTH-1:0]     rem_next_o
);

  // Multiplier state: multiplicand, shifting multiplier, product accumulator
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;

  // Divider state: divisor, dividend/quotient shift register, remainder.
  // The working remainder is WIDTH+1 bits wide only transiently (after the
  // shift); once the restoring compare is done it always fits in WIDTH bits.
  logic [WIDTH-1:0]   div_q,    div_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shifted;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;

  // Next-state logic for one radix-2 step of each engine, or a fresh load
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    div_d    = div_q;
    quo_d    = quo_q;
    rem_d    = rem_q;

    // Shift-add: conditionally add the multiplicand into the upper half,
    // keeping the carry so the right shift never loses a bit.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + ({(WIDTH+1){mplier_q[0]}} & {1'b0, mcand_q});

    // Restoring divide: bring the dividend MSB into the remainder, then
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and the dividend as remainder.
    rem_shifted = {rem_q, quo_q[WIDTH-1]};
    rem_ge      = (rem_shifted >= {1'b0, div_q});
    rem_diff    = rem_shifted[WIDTH-1:0] - div_q;

    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      div_d    = b_i;
      quo_d    = a_i;
      rem_d    = '0;
    end else if (step_i) begin
      acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      quo_d    = {quo_q[WIDTH-2:0], rem_ge};
      rem_d    = rem_ge ? rem_diff : rem_shifted[WIDTH-1:0];
    end
  end

  assign prod_next_o = acc_d;
  assign quo_next_o  = quo_d;
  assign rem_next_o  = rem_d;

  // Arithmetic state registers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULH/DIVU/REMU execute unit. Accepts operands from
// the RegisterFile read ports, runs WIDTH radix-2 steps, then issues a
// single-cycle write-back (wb_ad/wb_di/wb_we) toward the RegisterFile.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_a,
  input  logic [WIDTH-1:0] rs_b,
  input  logic [AW-1:0]    rd,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    wb_ad,
  output logic [WIDTH-1:0] wb_di,
  output logic             wb_we
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [1:0]       op_q,     op_d;
  logic [AW-1:0]    rd_q,     rd_d;
  logic             busy_q,   busy_d;
  logic             wb_q,     wb_d;
  logic [AW-1:0]    wb_ad_q,  wb_ad_d;
  logic [WIDTH-1:0] wb_di_q,  wb_di_d;

  logic             dp_load;
  logic             dp_step;
  logic             final_step;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] result;

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i       (CLK),
    .srst_i      (reset),
    .load_i      (dp_load),
    .step_i      (dp_step),
    .a_i         (rs_a),
    .b_i         (rs_b),
    .prod_next_o (prod_next),
    .quo_next_o  (quo_next),
    .rem_next_o  (rem_next)
  );

  assign dp_load    = (state_q == S_IDLE) && start;
  assign dp_step    = (state_q == S_RUN);
  assign final_step = dp_step && (count_q == LAST_STEP);

  // Pick the word to write back from the post-final-step arithmetic state
  always_comb begin
    result = rem_next;
    case (op_q)
      OP_MUL:  result = prod_next[WIDTH-1:0];
      OP_MULH: result = prod_next[2*WIDTH-1:WIDTH];
      OP_DIVU: result = quo_next;
      default: result = rem_next;
    endcase
  end

  // FSM sequencing, step counter, request latching and write-back capture
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wb_ad_d = wb_ad_q;
    wb_di_d = wb_di_q;
    wb_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
          op_d    = op;
          rd_d    = rd;
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        if (final_step) begin
          state_d = S_WB;
          wb_d    = 1'b1;
          wb_ad_d = rd_q;
          wb_di_d = result;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy covers RUN and WB; it falls on the edge that leaves WB.
    busy_d = (state_d != S_IDLE);
  end

  // Control and write-back registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      wb_q    <= 1'b0;
      wb_ad_q <= '0;
      wb_di_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      wb_q    <= wb_d;
      wb_ad_q <= wb_ad_d;
      wb_di_q <= wb_di_d;
    end
  end

  // A reset arriving during the WB cycle must suppress the register write,
  // so the enable is qualified with reset rather than waiting for the edge.
  assign wb_we = wb_q & ~reset;
  assign done  = wb_q & ~reset;
  assign busy  = busy_q;
  assign wb_ad = wb_ad_q;
  assign wb_di = wb_di_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations checked against a plain-arithmetic reference model, with a
// small RegisterFile model fed by the write-back port.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int A = 5;
  localparam int LAT = 32;  // edges from the accepting edge to the WB cycle

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_a = '0;
  logic [W-1:0] rs_b = '0;
  logic [A-1:0] rd = '0;
  logic         busy, done, wb_we;
  logic [A-1:0] wb_ad;
  logic [W-1:0] wb_di;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cnt = 0;
  logic [W-1:0] rf [32];

  muldiv_unit #(.WIDTH(W), .AW(A)) dut (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs_a  (rs_a),
    .rs_b  (rs_b),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .wb_ad (wb_ad),
    .wb_di (wb_di),
    .wb_we (wb_we)
  );

  always #5 CLK = ~CLK;

  // Cycle counter and RegisterFile write port model
  always @(posedge CLK) begin
    cyc++;
    if (wb_we) begin
      wr_cnt++;
      rf[wb_ad] = wb_di;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      OP_MUL:  return p[31:0];
      OP_MULH: return p[63:32];
      OP_DIVU: return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Present a request for one edge, then scramble the inputs so the unit
  // can only produce the right answer from its latched copies.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [A-1:0] r);
    op = o; rs_a = a; rs_b = b; rd = r; start = 1'b1;
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    op = 2'($urandom); rs_a = W'($urandom); rs_b = W'($urandom); rd = A'($urandom);
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic await_wb(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [A-1:0] r);
    logic [W-1:0] exp;
    logic seen;
    int w0;
    exp = model(o, a, b);
    seen = 1'b0;
    w0 = wr_cnt;
    while (!seen && (cyc - acc_cyc) < LAT + 8) begin
      @(posedge CLK);
      #1;
      if (wb_we) seen = 1'b1;
    end
    chk({name, "_wb_seen"}, {63'b0, seen}, 64'd1);
    chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'(LAT));
    chk({name, "_wb_ad"}, 64'(wb_ad), 64'(r));
    chk({name, "_wb_di"}, 64'(wb_di), 64'(exp));
    chk({name, "_done"}, {63'b0, done}, 64'd1);
    chk({name, "_busy_in_wb"}, {63'b0, busy}, 64'd1);
    $display("txn %s op=%0d a=0x%h b=0x%h rd=%0d -> wb_di=0x%h lat=%0d",
             name, o, a, b, r, wb_di, cyc - acc_cyc);
    @(posedge CLK);
    #1;
    chk({name, "_we_after"}, {63'b0, wb_we}, 64'd0);
    chk({name, "_done_after"}, {63'b0, done}, 64'd0);
    chk({name, "_busy_after"}, {63'b0, busy}, 64'd0);
    chk({name, "_di_hold"}, 64'(wb_di), 64'(exp));
    chk({name, "_one_write"}, 64'(wr_cnt - w0), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [A-1:0] r);
    launch(o, a, b, r);
    await_wb(name, o, a, b, r);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_busy"}, {63'b0, busy}, 64'd0);
    chk({name, "_we"}, {63'b0, wb_we}, 64'd0);
    chk({name, "_done"}, {63'b0, done}, 64'd0);
    chk({name, "_wb_ad"}, 64'(wb_ad), 64'd0);
    chk({name, "_wb_di"}, 64'(wb_di), 64'd0);
  endtask

  initial begin
    int w0;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    logic [A-1:0] rr;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    @(posedge CLK);
    #1;
    check_idle_outputs("reset");

    // Directed cases
    run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd3);
    run_op("mulh_max", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    run_op("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd5);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd6);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd6);
    run_op("mul_rd0", OP_MUL, 32'd9, 32'd9, 5'd0);

    // A start pulse during RUN must be ignored
    launch(OP_DIVU, 32'd1000, 32'd7, 5'd9);
    repeat (9) @(posedge CLK);
    #1;
    op = OP_MUL; rs_a = 32'd3; rs_b = 32'd3; rd = 5'd12; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    await_wb("divu_ignore_start", OP_DIVU, 32'd1000, 32'd7, 5'd9);
    w0 = wr_cnt;
    repeat (LAT + 4) @(posedge CLK);
    #1;
    chk("ignored_start_no_write", 64'(wr_cnt - w0), 64'd0);

    // Reset in the middle of RUN
    launch(OP_MUL, 32'd1234, 32'd5678, 5'd8);
    w0 = wr_cnt;
    repeat (9) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset_run");
    repeat (LAT + 4) @(posedge CLK);
    #1;
    chk("reset_run_no_write", 64'(wr_cnt - w0), 64'd0);
    run_op("mul_after_reset", OP_MUL, 32'd2, 32'd2, 5'd10);

    // Reset coinciding with the WB cycle suppresses the write
    launch(OP_MUL, 32'd5, 32'd5, 5'd7);
    w0 = wr_cnt;
    repeat (LAT) @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_wb_we_gated", {63'b0, wb_we}, 64'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset_wb");
    chk("reset_wb_no_write", 64'(wr_cnt - w0), 64'd0);

    // Reset and start on the same edge: reset wins
    reset = 1'b1; start = 1'b1; op = OP_MUL; rs_a = 32'd3; rs_b = 32'd3; rd = 5'd2;
    @(posedge CLK);
    #1;
    reset = 1'b0; start = 1'b0;
    chk("reset_start_busy", {63'b0, busy}, 64'd0);
    w0 = wr_cnt;
    repeat (LAT + 4) @(posedge CLK);
    #1;
    chk("reset_start_no_write", 64'(wr_cnt - w0), 64'd0);

    // Integration with the RegisterFile model
    run_op("mul_12x10", OP_MUL, 32'd12, 32'd10, 5'd4);
    chk("rf_read_r4", 64'(rf[4]), 64'd120);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      rr = A'($urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rb, rr);
      chk($sformatf("rand%0d_rf", i), 64'(rf[rr]), 64'(model(ro, ra, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit sitting directly downstream of RegisterFile.
- Consumes the two read-port operands (do1, do2) and produces a one-cycle write-back (address, data, enable) that drives RegisterFile ad/di/we.
- Covers the unsigned MUL/MULH/DIVU/REMU operations that the single-cycle ALU does not implement.
- Radix-2: one result bit per clock; start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits.
- AW, 5, register address width; must match RegisterFile.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULH (unsigned high word), 10 DIVU (quotient), 11 REMU (remainder).
- rs_a  input  WIDTH  operand A (multiplicand/dividend), from RegisterFile do1.
- rs_b  input  WIDTH  operand B (multiplier/divisor), from RegisterFile do2.
- rd  input  AW  destination register index.
- busy  output  1  high from the accepting edge until the WB cycle ends.
- done  output  1  one-cycle pulse, coincident with wb_we.
- wb_ad  output  AW  write-back address, to RegisterFile ad.
- wb_di  output  WIDTH  write-back data, to RegisterFile di.
- wb_we  output  1  write-back enable, to RegisterFile we.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE; busy, done, wb_we = 0; wb_ad = 0; wb_di = 0; internal accumulators and counter = 0.
- FSM states: IDLE, RUN, WB.
- IDLE -> RUN on an edge with start=1.
  - Latch op, rd, rs_a, rs_b.
  - Clear the 2*WIDTH accumulator (multiply) or the WIDTH+1 partial remainder (divide).
  - Set count = 0 and busy = 1.
- RUN lasts exactly WIDTH cycles; count increments each cycle.
- MUL/MULH step (shift-add):
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator.
  - Shift the {carry, accumulator} right by 1.
- DIVU/REMU step (restoring):
  - Shift {rem, quotient} left, bringing in the dividend MSB.
  - If rem >= divisor, subtract the divisor and set quotient LSB = 1.
- RUN -> WB when count == WIDTH-1.
- WB (one cycle):
  - wb_we = 1, done = 1, wb_ad = latched rd.
  - wb_di = low word (MUL), high word (MULH), quotient (DIVU) or remainder (REMU).
  - Next state is IDLE; busy drops on the following edge.
- Latency: an accepting edge at cycle N gives wb_we high during cycle N+WIDTH+1 (33 for the default WIDTH). A new start can be accepted at N+WIDTH+2.
- Outside WB, wb_we = 0 and done = 0. wb_di and wb_ad hold their last value.
- start while busy: ignored, no queueing. Operands presented then are never latched.
- Divide by zero: the result comes from the algorithm naturally, with no special path.
  - DIVU returns all ones (0xFFFFFFFF).
  - REMU returns rs_a.
  - Latency is unchanged.
- rd = 0: the write-back is still issued. Register-0 policy belongs to RegisterFile.
- Operand changes after acceptance have no effect, because values are latched.
- Reset mid-operation (RUN or WB): on the next edge, return to IDLE with all outputs at reset values. No write-back is issued, including when reset coincides with the WB cycle.
- reset and start high on the same edge: reset wins and start is discarded.

Decomposition:
- Shared package/header holds:
  - OP_MUL = 2'b00, OP_MULH = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11.
  - FSM state encodings S_IDLE, S_RUN, S_WB.
  - Default WIDTH and AW constants, shared with RegisterFile.
- One natural sub-module, muldiv_datapath: the accumulator/remainder registers and the add/subtract step logic.
- muldiv_unit keeps the FSM, counter, latches and write-back outputs.

Test Plan:
- MUL, rs_a=7, rs_b=6, rd=3 -> busy the cycle after start; wb_we=1 with wb_ad=3, wb_di=42 exactly 33 cycles after the accepting edge; done pulses once; busy=0 the next cycle.
- MULH, rs_a=0xFFFFFFFF, rs_b=0xFFFFFFFF, rd=31 -> wb_di=0xFFFFFFFE, wb_ad=31. Follow with MUL on the same operands -> wb_di=0x00000001.
- DIVU then REMU, 100 / 7, rd=5 -> wb_di=14, then wb_di=2. Each takes 33 cycles; the second start is issued the cycle busy falls.
- Divide by zero, rs_a=5, rs_b=0 -> DIVU wb_di=0xFFFFFFFF; REMU wb_di=5; no hang, same latency.
- start pulsed with op=MUL, 3*3, at cycle 10 of a running DIVU -> ignored; exactly one wb_we with the DIVU result; no second write-back.
- reset asserted at cycle 10 of RUN -> next edge busy=0, wb_we never rises. A following MUL 2*2 completes with wb_di=4.
- Integration: connect wb_ad/wb_di/wb_we to RegisterFile. After MUL 12*10 to rd=4, RegisterFile read port 1 with a1=4 shows 120.
